if_prefetch_unit: RTL and testbench
===================================

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameter WIDTH, 16, width of instruction words and addresses.
REQ-002 Parameter DEPTH, 4, prefetch queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, 16'h0000, fetch address after reset (bit 0 ignored).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  permits issue of new fetch requests.
REQ-007 mem_read  output  1  fetch request to instruction memory.
REQ-008 mem_addr  output  WIDTH  fetch address; bit 0 always 0.
REQ-009 mem_resp  input  1  one-cycle completion of the current request.
REQ-010 mem_rdata  input  WIDTH  instruction word, valid with mem_resp.
REQ-011 redirect  input  1  control-flow change (branch/JMP/JSR/TRAP resolved downstream).
REQ-012 redirect_pc  input  WIDTH  new fetch address, valid with redirect.
REQ-013 inst_ready  input  1  decode stage accepts the head instruction.
REQ-014 inst_valid  output  1  queue head holds a valid instruction.
REQ-015 inst  output  WIDTH  head instruction word.
REQ-016 inst_pc  output  WIDTH  address of head instruction plus 2 (LC-3b PC semantics).

Function
REQ-017 Fetch FSM SHALL have states IDLE, REQ, DROP; mem_read = 1 in REQ and DROP, 0 in IDLE.
REQ-018 IDLE->REQ when run=1, redirect=0 and queue count < DEPTH; mem_addr latched from fetch_pc on that edge.
REQ-019 mem_addr SHALL stay stable and mem_read high from entry into REQ/DROP until the cycle mem_resp=1.
REQ-020 REQ with mem_resp=1, redirect=0: enqueue {mem_rdata, mem_addr+2}; fetch_pc <= mem_addr+2 (mod 2^WIDTH); next state IDLE.
REQ-021 At most one request outstanding; a new request SHALL NOT issue in the cycle a response is accepted (min 1 IDLE cycle between requests).
REQ-022 redirect=1 in any state: queue flushed (count <= 0), fetch_pc <= {redirect_pc[WIDTH-1:1],1'b0}.
REQ-023 redirect in REQ with mem_resp=0: next state DROP; in DROP the response is discarded, then IDLE.
REQ-024 redirect coincident with mem_resp (REQ or DROP): response discarded, next state IDLE, no DROP cycle.
REQ-025 redirect in DROP: fetch_pc updated, state stays DROP until mem_resp.
REQ-026 Dequeue occurs when inst_valid & inst_ready & !redirect; head advances by one.
REQ-027 inst_valid = (count != 0); inst/inst_pc driven directly from head entry (no extra latency).
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged, including at count = DEPTH-1 and when head equals the enqueued slot's predecessor.
REQ-029 Read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH, full never overwritten.
REQ-030 run=0 blocks only IDLE->REQ; an outstanding request completes and is enqueued normally.
REQ-031 Latency: mem_resp in cycle N -> inst_valid=1 with that word in cycle N+1 (if queue was empty).
REQ-032 No output SHALL depend combinationally on mem_resp/mem_rdata.

Reset
REQ-033 reset_n=0 SHALL immediately force: state IDLE, mem_read=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, pointers=0, inst_valid=0, inst=0, inst_pc=0.
REQ-034 Reset asserted mid-request abandons the request; a late mem_resp after release while IDLE SHALL be ignored.
REQ-035 First request after reset_n rises: mem_read=1 from the edge after run=1 is sampled.

Verification
REQ-036 Reset release, run=1, memory answers 1 cycle after each request with 0x1000,0x1001,...; inst_ready=1 -> mem_addr 0x0000,0x0002,0x0004; inst/inst_pc pairs (0x1000,0x0002),(0x1001,0x0004).
REQ-037 inst_ready=0, DEPTH=4 -> exactly 4 enqueues, mem_read stays 0 afterwards; inst_ready=1 for one cycle -> count 3, one new request issued.
REQ-038 redirect_pc=0x3001 while REQ pending, mem_resp 3 cycles later -> response discarded, inst_valid=0, next mem_addr=0x3000.
REQ-039 redirect and mem_resp in same cycle -> queue empty next cycle, state IDLE, next request to redirect_pc.
REQ-040 fetch_pc=0xFFFE, response accepted -> inst_pc=0x0000, next mem_addr=0x0000.
REQ-041 reset_n pulsed low mid-REQ with queue count 2 -> all outputs at reset values asynchronously; stray mem_resp ignored.

Source files
------------

// File: rtl/if_prefetch_unit_if.sv
// Fetch/decode/memory handshake bundle for the instruction prefetch unit.
// master = prefetch unit, slave = environment (memory + decode + redirect source).
interface if_prefetch_unit_if #(
  parameter int WIDTH = 16
) ();
  logic             run;
  logic             mem_read;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             inst_ready;
  logic             inst_valid;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;

  modport master (
    input  run, mem_resp, mem_rdata, redirect, redirect_pc, inst_ready,
    output mem_read, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output run, mem_resp, mem_rdata, redirect, redirect_pc, inst_ready,
    input  mem_read, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: single-outstanding fetch FSM feeding a DEPTH-entry
// queue of {word, pc+2}. Redirects flush the queue and squash in-flight fetches.
module if_prefetch_unit #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset_n,
  if_prefetch_unit_if.master  pf
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] EVEN_MASK = ~WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_ADDR  = RESET_PC & EVEN_MASK;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] pc;
  } entry_t;

  state_t           state;
  logic             mem_read_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] fetch_pc;

  entry_t           q [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  logic             enq, deq, has_room;
  logic [WIDTH-1:0] redir_pc, seq_pc;

  // Only a live REQ response is kept; DROP responses and redirect cycles are squashed.
  assign enq      = (state == S_REQ) && pf.mem_resp && !pf.redirect;
  assign deq      = (count != '0) && pf.inst_ready && !pf.redirect;
  assign has_room = (count < CW'(DEPTH));
  assign redir_pc = pf.redirect_pc & EVEN_MASK;
  assign seq_pc   = mem_addr_q + WIDTH'(2);

  assign pf.mem_read   = mem_read_q;
  assign pf.mem_addr   = mem_addr_q;
  assign pf.inst_valid = (count != '0);
  assign pf.inst       = q[rd_ptr].word;
  assign pf.inst_pc    = q[rd_ptr].pc;

  // Fetch FSM: issues one request at a time, holds address until the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= RST_ADDR;
      fetch_pc   <= RST_ADDR;
    end else begin
      case (state)
        S_IDLE: begin
          if (pf.redirect) begin
            fetch_pc <= redir_pc;
          end else if (pf.run && has_room) begin
            state      <= S_REQ;
            mem_read_q <= 1'b1;
            mem_addr_q <= fetch_pc;
          end
        end
        S_REQ: begin
          if (pf.mem_resp) begin
            state      <= S_IDLE;
            mem_read_q <= 1'b0;
            fetch_pc   <= pf.redirect ? redir_pc : seq_pc;
          end else if (pf.redirect) begin
            state    <= S_DROP;
            fetch_pc <= redir_pc;
          end
        end
        S_DROP: begin
          if (pf.redirect) fetch_pc <= redir_pc;
          if (pf.mem_resp) begin
            state      <= S_IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch queue: circular buffer; a request is only issued with room, so
  // an enqueue can never land on a full queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (pf.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        q[wr_ptr] <= '{word: pf.mem_rdata, pc: seq_pc};
        wr_ptr    <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized scoreboard bench for if_prefetch_unit. The model tracks the
// architectural fetch address and the ordered list of words the decode stage
// should receive; a separate monitor pops and compares on each accepted word.
module tb_if_prefetch_unit;
  localparam int W = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] word;
    logic [W-1:0] pc;
  } ent_t;

  logic clk, reset_n;
  if_prefetch_unit_if #(.WIDTH(W)) pf ();

  if_prefetch_unit #(.WIDTH(W), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .pf(pf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model state
  ent_t         sb[$];
  logic [W-1:0] exp_fetch;
  logic         pending, cancelled;
  int           lat;
  logic [W-1:0] cur_addr;
  logic         d_push, d_flush;
  ent_t         d_ent;
  logic         p_mr, p_resp, p_run, p_redir;
  int           cnt_seen;
  logic         mon_en;
  logic         force_redir;
  logic [W-1:0] force_pc;

  // Monitor: mid-cycle, compare valid against model occupancy and pop on accept.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inst_valid", {31'd0, pf.inst_valid}, {31'd0, sb.size() != 0});
      cnt_seen = sb.size();
      if (pf.inst_valid && pf.inst_ready && !pf.redirect && sb.size() != 0) begin
        ent_t e;
        e = sb.pop_front();
        chk("inst", {16'd0, pf.inst}, {16'd0, e.word});
        chk("inst_pc", {16'd0, pf.inst_pc}, {16'd0, e.pc});
      end
    end
  end

  task automatic model_init();
    sb.delete();
    exp_fetch = 16'h0000;
    pending = 0; cancelled = 0; lat = 0;
    d_push = 0; d_flush = 0;
    p_mr = 0; p_resp = pf.mem_resp; p_run = pf.run; p_redir = pf.redirect;
    cnt_seen = 0;
  endtask

  function automatic logic [W-1:0] pick_pc();
    case ($urandom % 4)
      0: return 16'h3001;
      1: return 16'hFFFF;
      2: return 16'hFFFC;
      default: return W'($urandom);
    endcase
  endfunction

  // One cycle of stimulus: check issue behaviour, then drive next inputs.
  task automatic step(input int run_pct, input int rdy_pct, input int redir_pct,
                      input int lat_min, input int lat_max);
    logic exp_mr;
    logic [W-1:0] data;
    @(posedge clk); #2;
    if (d_flush) sb.delete();
    if (d_push) sb.push_back(d_ent);
    d_flush = 0; d_push = 0;

    exp_mr = p_mr ? !p_resp : (p_run && !p_redir && cnt_seen < DEPTH);
    chk("mem_read", {31'd0, pf.mem_read}, {31'd0, exp_mr});
    if (pf.mem_read && !pending) begin
      chk("mem_addr_issue", {16'd0, pf.mem_addr}, {16'd0, exp_fetch});
      pending = 1; cancelled = 0;
      cur_addr = pf.mem_addr;
      lat = $urandom_range(lat_max, lat_min);
    end else if (pf.mem_read) begin
      chk("mem_addr_hold", {16'd0, pf.mem_addr}, {16'd0, cur_addr});
    end

    pf.run         = ($urandom % 100) < run_pct;
    pf.inst_ready  = ($urandom % 100) < rdy_pct;
    pf.redirect    = force_redir || (($urandom % 100) < redir_pct);
    pf.redirect_pc = force_redir ? force_pc : pick_pc();
    force_redir    = 0;
    pf.mem_resp    = 0;
    pf.mem_rdata   = W'($urandom);

    if (pending) begin
      if (lat == 0) begin
        data = W'($urandom);
        pf.mem_resp  = 1;
        pf.mem_rdata = data;
        if (!pf.redirect && !cancelled) begin
          d_push = 1;
          d_ent = '{word: data, pc: cur_addr + 16'd2};
          exp_fetch = cur_addr + 16'd2;
        end
        pending = 0;
      end else begin
        lat--;
      end
    end else if (!pf.mem_read && ($urandom % 100) < 5) begin
      pf.mem_resp = 1;  // stray response while idle must be ignored
    end

    if (pf.redirect) begin
      d_flush = 1;
      exp_fetch = pf.redirect_pc & 16'hFFFE;
      if (pending) cancelled = 1;
    end

    p_mr = pf.mem_read; p_resp = pf.mem_resp; p_run = pf.run; p_redir = pf.redirect;
  endtask

  task automatic drive_idle();
    pf.run = 0; pf.mem_resp = 0; pf.mem_rdata = '0; pf.redirect = 0;
    pf.redirect_pc = '0; pf.inst_ready = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_read"},   {31'd0, pf.mem_read},   32'd0);
    chk({tag, "_mem_addr"},   {16'd0, pf.mem_addr},   32'd0);
    chk({tag, "_inst_valid"}, {31'd0, pf.inst_valid}, 32'd0);
    chk({tag, "_inst"},       {16'd0, pf.inst},       32'd0);
    chk({tag, "_inst_pc"},    {16'd0, pf.inst_pc},    32'd0);
  endtask

  initial begin
    logic found;
    mon_en = 0; force_redir = 0; force_pc = '0;
    drive_idle();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #2 chk_reset_outputs("reset");
    reset_n = 1;
    model_init();
    mon_en = 1;

    // straight-line fetch, memory answers one cycle after each request
    repeat (20) step(100, 100, 0, 1, 1);
    // decode stalled: queue fills and fetching stops
    repeat (30) step(100, 0, 0, 0, 2);
    // single accept frees one slot
    step(100, 100, 0, 0, 2);
    repeat (10) step(100, 0, 0, 0, 2);
    // mixed random traffic
    repeat (3000) step(80, 60, 8, 0, 4);
    // redirect near the top of the address space to exercise wrap
    force_redir = 1; force_pc = 16'hFFFF;
    step(100, 100, 0, 2, 2);
    repeat (20) step(100, 100, 0, 0, 1);

    // async reset while a request is outstanding and two words are queued
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(100, 0, 0, 3, 3);
      if (sb.size() == 2 && pf.mem_read && pending && !pf.mem_resp) found = 1;
      if (sb.size() == DEPTH) begin
        force_redir = 1; force_pc = 16'h0100;
      end
    end
    chk("reset_setup_found", {31'd0, found}, 32'd1);
    mon_en = 0;
    #1 reset_n = 0;
    #1 chk_reset_outputs("async_reset");
    drive_idle();
    @(posedge clk); #2 reset_n = 1;
    @(posedge clk); #2 pf.mem_resp = 1; pf.mem_rdata = 16'hBEEF;
    @(posedge clk); #2 pf.mem_resp = 0;
    chk("stray_inst_valid", {31'd0, pf.inst_valid}, 32'd0);
    chk("stray_mem_read",   {31'd0, pf.mem_read},   32'd0);
    model_init();
    mon_en = 1;
    repeat (500) step(80, 60, 8, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
